// File: rtl/ternary_lift_stream.sv
// Streams a captured ternary vector as mod-2^QW coefficients over a valid/ready
// handshake; the highest index has no source bits and always streams as zero.
module ternary_lift_stream #(
   parameter int N  = 701,
   parameter int QW = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2*(N-1):1]  tern_in,
   input  logic              start,
   output logic              busy,
   output logic [QW-1:0]     coef_out,
   output logic [9:0]        coef_idx,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic              done,
   output logic              err
);

   localparam int          SW   = 2 * (N - 1);
   localparam logic [9:0]  LAST = 10'(N - 1);

   typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

   state_t           r_state;
   logic [SW-1:0]    r_shift;
   logic [9:0]       r_idx;
   logic [QW-1:0]    r_out;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_xfer;
   logic             w_last;
   logic             w_next_last;

   function automatic logic [QW-1:0] lift(input logic [1:0] code);
      logic [QW-1:0] v;
      case (code)
         2'd1:    v = QW'(1);
         2'd2:    v = '1;
         default: v = '0;
      endcase
      return v;
   endfunction

   assign w_xfer      = r_valid & coef_ready;
   assign w_last      = (r_idx == LAST);
   assign w_next_last = (r_idx == LAST - 10'd1);

   // r_shift[1:0] always holds the code of the coefficient currently on coef_out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_shift <= tern_in;
                  r_idx   <= '0;
                  r_err   <= 1'b0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_out   <= lift(tern_in[2:1]);
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (w_xfer) begin
                  r_err <= r_err | (!w_last && r_shift[1:0] == 2'd3);
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_out   <= '0;
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else begin
                     r_shift <= {2'b00, r_shift[SW-1:2]};
                     r_idx   <= r_idx + 10'd1;
                     r_out   <= w_next_last ? '0 : lift(r_shift[3:2]);
                  end
               end
            end
            FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign coef_out   = r_out;
   assign coef_idx   = r_idx;
   assign coef_valid = r_valid;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_ternary_lift_stream.sv
// Scenario bench for ternary_lift_stream: expected coefficients are queued at
// start and popped on each observed transfer.
module tb_ternary_lift_stream;

   localparam int N  = 701;
   localparam int QW = 13;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1400:1]     tern_in = '0;
   logic              start = 1'b0;
   logic              busy;
   logic [QW-1:0]     coef_out;
   logic [9:0]        coef_idx;
   logic              coef_valid;
   logic              coef_ready = 1'b0;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   ternary_lift_stream #(.N(N), .QW(QW)) dut (
      .clk        (clk),
      .rst        (rst),
      .tern_in    (tern_in),
      .start      (start),
      .busy       (busy),
      .coef_out   (coef_out),
      .coef_idx   (coef_idx),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [1400:1] rand_vec();
      logic [1400:1] v;
      v = '0;
      for (int i = 0; i < 700; i++) v[2*i+1 +: 2] = 2'($urandom_range(2));
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      tern_in = rand_vec();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      checks += 6;
      if (coef_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", coef_valid); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      if (coef_idx !== 10'd0)  begin errors++; $display("FAIL reset_idx got %0d exp 0", coef_idx); end
      if (coef_out !== '0)     begin errors++; $display("FAIL reset_out got %0d exp 0", coef_out); end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_discard busy got %b exp 0", busy); end
      $display("test_reset: done");
   endtask

   // One full run: queue expectations, pulse start, watch every cycle.
   task automatic run_stream(input string name, input logic [1400:1] vec, input int pct,
                             input bit mid_start, input int abort_idx);
      logic [QW-1:0] exp_q[$];
      bit            bad_q[$];
      int            idx_q[$];
      logic [QW-1:0] e_out, po;
      logic [9:0]    pi;
      logic [1:0]    c;
      bit            e_bad, exp_err, pv, pr, aborted;
      int            e_idx, transfers, cyc, first_cyc, last_cyc;

      exp_err = 0; pv = 0; pr = 0; aborted = 0;
      transfers = 0; cyc = 0; first_cyc = -1; last_cyc = 0;
      po = '0; pi = '0;
      for (int i = 0; i < 700; i++) begin
         c = vec[2*i+1 +: 2];
         exp_q.push_back(c == 2'd1 ? 13'd1 : (c == 2'd2 ? 13'd8191 : 13'd0));
         bad_q.push_back(c == 2'd3);
         idx_q.push_back(i);
      end
      exp_q.push_back(13'd0);
      bad_q.push_back(1'b0);
      idx_q.push_back(700);

      @(posedge clk);
      #1;
      tern_in = vec;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      coef_ready = ($urandom_range(99) < pct);
      checks += 3;
      if (coef_valid !== 1'b1) begin errors++; $display("FAIL %s first_valid got %b exp 1", name, coef_valid); end
      if (coef_idx !== 10'd0)  begin errors++; $display("FAIL %s first_idx got %0d exp 0", name, coef_idx); end
      if (busy !== 1'b1)       begin errors++; $display("FAIL %s busy_after_start got %b exp 1", name, busy); end

      while (transfers < N && cyc < 20000 && !aborted) begin
         @(negedge clk);
         if (abort_idx >= 0 && coef_valid && int'(coef_idx) == abort_idx) begin
            aborted = 1;
         end else begin
            if (pv && !pr && coef_valid) begin
               checks++;
               if (coef_out !== po || coef_idx !== pi) begin
                  errors++;
                  $display("FAIL %s stall_hold got idx %0d out %0d exp idx %0d out %0d",
                           name, coef_idx, coef_out, pi, po);
               end
            end
            if (coef_valid) begin
               checks++;
               if (err !== exp_err) begin
                  errors++;
                  $display("FAIL %s err_flag idx %0d got %b exp %b", name, coef_idx, err, exp_err);
               end
            end
            if (coef_valid && coef_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL %s extra_transfer got idx %0d exp none", name, coef_idx);
               end else begin
                  e_out = exp_q.pop_front();
                  e_idx = idx_q.pop_front();
                  e_bad = bad_q.pop_front();
                  checks++;
                  if (coef_out !== e_out || int'(coef_idx) != e_idx) begin
                     errors++;
                     $display("FAIL %s coef got idx %0d out %0d exp idx %0d out %0d",
                              name, coef_idx, coef_out, e_idx, e_out);
                  end
                  if (e_bad) exp_err = 1;
               end
               transfers++;
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
            end
            pv = coef_valid; pr = coef_ready; po = coef_out; pi = coef_idx;
            @(posedge clk);
            #1;
            cyc++;
            coef_ready = ($urandom_range(99) < pct);
            if (mid_start && cyc == 100) begin
               start = 1'b1;
               tern_in = rand_vec();
            end else begin
               start = 1'b0;
            end
         end
      end

      if (aborted) begin
         rst = 1'b1;
         start = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         start = 1'b0;
         checks += 3;
         if (coef_valid !== 1'b0) begin errors++; $display("FAIL %s abort_valid got %b exp 0", name, coef_valid); end
         if (busy !== 1'b0)       begin errors++; $display("FAIL %s abort_busy got %b exp 0", name, busy); end
         if (coef_idx !== 10'd0)  begin errors++; $display("FAIL %s abort_idx got %0d exp 0", name, coef_idx); end
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || coef_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s abort_quiet got done %b valid %b exp 0 0", name, done, coef_valid);
            end
         end
         $display("%s: aborted at idx %0d after %0d transfers", name, abort_idx, transfers);
      end else if (transfers < N) begin
         checks++; errors++;
         $display("FAIL %s timeout got %0d transfers exp %0d", name, transfers, N);
      end else begin
         checks += 4;
         if (done !== 1'b1)       begin errors++; $display("FAIL %s done_pulse got %b exp 1", name, done); end
         if (coef_valid !== 1'b0) begin errors++; $display("FAIL %s valid_after_last got %b exp 0", name, coef_valid); end
         if (err !== exp_err)     begin errors++; $display("FAIL %s err_at_done got %b exp %b", name, err, exp_err); end
         if (exp_q.size() != 0)   begin errors++; $display("FAIL %s leftover got %0d exp 0", name, exp_q.size()); end
         if (pct >= 100) begin
            checks++;
            if (last_cyc - first_cyc + 1 != N) begin
               errors++;
               $display("FAIL %s back_to_back got %0d cycles exp %0d", name, last_cyc - first_cyc + 1, N);
            end
         end
         @(posedge clk);
         #1;
         checks += 3;
         if (done !== 1'b0)   begin errors++; $display("FAIL %s done_width got %b exp 0", name, done); end
         if (busy !== 1'b0)   begin errors++; $display("FAIL %s busy_after_fin got %b exp 0", name, busy); end
         if (err !== exp_err) begin errors++; $display("FAIL %s err_sticky got %b exp %b", name, err, exp_err); end
         $display("%s: %0d transfers in %0d cycles, err=%b", name, transfers, cyc, err);
      end
      coef_ready = 1'b1;
   endtask

   task automatic test_all_zero();
      run_stream("all_zero", '0, 100, 0, -1);
   endtask

   task automatic test_low_coeffs();
      logic [1400:1] v;
      v = '0;
      v[2:1] = 2'd1;
      v[4:3] = 2'd2;
      run_stream("low_coeffs", v, 100, 0, -1);
   endtask

   task automatic test_top_coeff();
      logic [1400:1] v;
      v = '0;
      v[1400:1399] = 2'd2;
      run_stream("top_coeff", v, 100, 0, -1);
   endtask

   task automatic test_random_stall();
      run_stream("random_stall", rand_vec(), 50, 1, -1);
   endtask

   task automatic test_err_code();
      logic [1400:1] v;
      v = rand_vec();
      v[6:5] = 2'd3;
      run_stream("err_code", v, 70, 0, -1);
      run_stream("err_clear", rand_vec(), 100, 0, -1);
   endtask

   task automatic test_abort();
      run_stream("abort", rand_vec(), 100, 0, 350);
   endtask

   task automatic test_back_to_back();
      run_stream("back_to_back", rand_vec(), 100, 0, -1);
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_low_coeffs();
      test_top_coeff();
      test_random_stall();
      test_err_code();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ternary_lift_stream.md
TERNARY_LIFT_STREAM -- requirements
Module: ternary_lift_stream

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter N, default 701, giving the number of coefficients emitted per run (polynomial degree bound n).
- REQ-002 The block SHALL have parameter QW, default 13, giving the width of each emitted mod-q coefficient (q = 2^QW = 8192).

Ports (name, direction, width, meaning):
- REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
- REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 The block SHALL have port tern_in, input, [1400:1]: packed ternary vector; coefficient i (0..699) = tern_in[2i+2:2i+1], encoding 0->0, 1->+1, 2->-1.
- REQ-006 The block SHALL have port start, input, 1: one-cycle request to capture tern_in and begin a run.
- REQ-007 The block SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
- REQ-008 The block SHALL have port coef_out, output, [QW-1:0]: current lifted coefficient.
- REQ-009 The block SHALL have port coef_idx, output, [9:0]: index of coef_out, 0..N-1.
- REQ-010 The block SHALL have port coef_valid, output, 1: coef_out/coef_idx are valid.
- REQ-011 The block SHALL have port coef_ready, input, 1: consumer accepts the coefficient.
- REQ-012 The block SHALL have port done, output, 1: one-cycle pulse after the last transfer.
- REQ-013 The block SHALL have port err, output, 1: sticky flag; set if any captured 2-bit code equals 3.

Function
- REQ-014 The FSM SHALL have states IDLE, STREAM and FIN.
- REQ-015 In IDLE with start=1, the block SHALL load tern_in into an internal 1400-bit shift register, clear err and the index counter, and go to STREAM.
- REQ-016 The first coefficient (idx 0) SHALL be presented with coef_valid=1 in the cycle after start is sampled (latency 1).
- REQ-017 Lift rule: code 0 -> 0; code 1 -> 1; code 2 -> 2^QW-1 (8191); code 3 -> 0 with err set.
- REQ-018 Index N-1 (700) SHALL have no source bits and SHALL be emitted as 0.
- REQ-019 A transfer SHALL occur on a posedge with coef_valid & coef_ready; only a transfer SHALL advance the index and shift the register right by 2.
- REQ-020 While coef_valid=1 and coef_ready=0, coef_out and coef_idx SHALL hold stable.
- REQ-021 Back-to-back: with coef_ready held 1, the block SHALL sustain one transfer per cycle, so N transfers take N cycles.
- REQ-022 A transfer at idx N-1 SHALL move the FSM to FIN and drop coef_valid in the next cycle.
- REQ-023 FIN SHALL last exactly one cycle, assert done=1, then return to IDLE with busy=0.
- REQ-024 start while busy or in FIN SHALL be ignored and SHALL NOT alter captured data or the index.
- REQ-025 coef_ready while coef_valid=0 SHALL be ignored.
- REQ-026 err SHALL remain set after the run until the next accepted start or reset.
- REQ-027 Counter width SHALL be 10 bits, and the index SHALL never exceed N-1 (no wrap).

Reset
- REQ-028 Reset SHALL be sampled on posedge clk; rst=1 forces IDLE, busy=0, coef_valid=0, done=0, err=0, coef_idx=0, coef_out=0, and clears the shift register.
- REQ-029 Reset mid-run SHALL abort the run with no done pulse; the next start SHALL restart from idx 0.
- REQ-030 rst and start in the same cycle: rst SHALL win, and start SHALL be discarded.

Verification
- REQ-031 All-zero tern_in, start, coef_ready=1 -> 701 transfers of 0, idx 0..700 in consecutive cycles, done pulse 1 cycle after the last transfer, err=0.
- REQ-032 tern_in[2:1]=1, tern_in[4:3]=2, rest 0 -> idx0=1, idx1=8191, idx2..700=0.
- REQ-033 tern_in[1400:1399]=2 -> idx699=8191, idx700=0.
- REQ-034 coef_ready toggled randomly -> each index transferred exactly once, in order, values stable while stalled; a start pulsed mid-run has no effect.
- REQ-035 tern_in[6:5]=3 -> idx2=0, err=1 after that transfer and through done; the next start clears err.
- REQ-036 rst asserted at idx 350 -> next cycle coef_valid=0, busy=0, with no done pulse; a fresh start emits idx 0 again.
